// File: rtl/aoc_job_sequencer.sv
// Job sequencer: parses the AA/L/H/Q header, streams line bytes to the solver core,
// accumulates per-line results and sends the sum out MSB first. All outputs are registered.
module aoc_job_sequencer #(
  parameter int SUM_W  = 64,
  parameter int LCNT_W = 12
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_err,
  output logic              core_start,
  output logic [3:0]        cfg_digits,
  output logic              core_byte_valid,
  output logic [7:0]        core_byte,
  output logic              core_last,
  input  logic              core_done,
  input  logic [SUM_W-1:0]  core_result,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int NB = SUM_W / 8;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [3:0] {
    IDLE, HDR_L, HDR_H, HDR_Q, START, LINE, WAIT_CORE, SEND, TX_WAIT, DONE
  } state_t;

  state_t             state_q;
  logic [SUM_W-1:0]   sum_q;
  logic [7:0]         l_q;
  logic [7:0]         h_q;
  logic [LCNT_W-1:0]  n_q;
  logic [LCNT_W-1:0]  line_cnt_q;
  logic [7:0]         byte_cnt_q;
  logic               hold_vld_q;
  logic [7:0]         hold_dat_q;
  logic [KW-1:0]      k_q;
  logic               guard_q;

  logic               core_start_q, core_byte_valid_q, core_last_q, tx_start_q;
  logic               busy_q, done_q, err_q;
  logic [3:0]         cfg_digits_q;
  logic [7:0]         core_byte_q, tx_data_q;
  logic [1:0]         err_code_q;

  logic [LCNT_W-1:0]  hdr_n;
  logic               is_last;
  logic [7:0]         line_fwd_dat;
  logic [SUM_W-1:0]   sum_shift;
  logic [1:0]         abort_code;

  assign hdr_n        = {h_q, rx_data[7:4]};
  assign is_last      = (byte_cnt_q == l_q - 8'd1);
  assign line_fwd_dat = hold_vld_q ? hold_dat_q : rx_data;
  assign sum_shift    = sum_q << {k_q, 3'b000};

  // rx errors abort any active job; a second early byte overruns the one-entry holding register
  always_comb begin
    abort_code = 2'd0;
    if (state_q != IDLE && rx_valid && rx_err)
      abort_code = 2'd2;
    else if ((state_q == START || state_q == WAIT_CORE) && rx_valid && hold_vld_q)
      abort_code = 2'd3;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q           <= IDLE;
      sum_q             <= '0;
      l_q               <= '0;
      h_q               <= '0;
      n_q               <= '0;
      line_cnt_q        <= '0;
      byte_cnt_q        <= '0;
      hold_vld_q        <= 1'b0;
      hold_dat_q        <= '0;
      k_q               <= '0;
      guard_q           <= 1'b0;
      core_start_q      <= 1'b0;
      core_byte_valid_q <= 1'b0;
      core_last_q       <= 1'b0;
      core_byte_q       <= '0;
      cfg_digits_q      <= '0;
      tx_start_q        <= 1'b0;
      tx_data_q         <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      err_q             <= 1'b0;
      err_code_q        <= '0;
    end else begin
      core_start_q      <= 1'b0;
      core_byte_valid_q <= 1'b0;
      core_last_q       <= 1'b0;
      tx_start_q        <= 1'b0;
      done_q            <= 1'b0;
      if (abort_code != 2'd0) begin
        state_q    <= IDLE;
        err_q      <= 1'b1;
        err_code_q <= abort_code;
        busy_q     <= 1'b0;
        hold_vld_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (rx_valid && !rx_err && rx_data == 8'hAA) begin
            state_q    <= HDR_L;
            sum_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            busy_q     <= 1'b1;
            hold_vld_q <= 1'b0;
          end
          HDR_L: if (rx_valid) begin
            l_q     <= rx_data;
            state_q <= HDR_H;
          end
          HDR_H: if (rx_valid) begin
            h_q     <= rx_data;
            state_q <= HDR_Q;
          end
          HDR_Q: if (rx_valid) begin
            if (l_q == 8'd0 || hdr_n == '0 || rx_data[3:0] == 4'd0) begin
              err_q      <= 1'b1;
              err_code_q <= 2'd1;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              n_q          <= hdr_n;
              cfg_digits_q <= rx_data[3:0];
              line_cnt_q   <= '0;
              byte_cnt_q   <= '0;
              core_start_q <= 1'b1;
              state_q      <= START;
            end
          end
          START: begin
            // A byte held over from WAIT_CORE goes out right behind core_start
            if (hold_vld_q) begin
              core_byte_valid_q <= 1'b1;
              core_byte_q       <= hold_dat_q;
              core_last_q       <= is_last;
              byte_cnt_q        <= byte_cnt_q + 8'd1;
              hold_vld_q        <= 1'b0;
              state_q           <= is_last ? WAIT_CORE : LINE;
            end else begin
              state_q <= LINE;
              if (rx_valid) begin
                hold_vld_q <= 1'b1;
                hold_dat_q <= rx_data;
              end
            end
          end
          LINE: if (hold_vld_q || rx_valid) begin
            core_byte_valid_q <= 1'b1;
            core_byte_q       <= line_fwd_dat;
            core_last_q       <= is_last;
            byte_cnt_q        <= byte_cnt_q + 8'd1;
            hold_vld_q        <= hold_vld_q && rx_valid;
            if (hold_vld_q && rx_valid) hold_dat_q <= rx_data;
            if (is_last) state_q <= WAIT_CORE;
          end
          WAIT_CORE: begin
            if (rx_valid) begin
              hold_vld_q <= 1'b1;
              hold_dat_q <= rx_data;
            end
            if (core_done) begin
              sum_q      <= sum_q + core_result;
              line_cnt_q <= line_cnt_q + LCNT_W'(1);
              if (line_cnt_q == n_q - LCNT_W'(1)) begin
                state_q <= SEND;
                k_q     <= '0;
              end else begin
                byte_cnt_q   <= '0;
                core_start_q <= 1'b1;
                state_q      <= START;
              end
            end
          end
          SEND: if (!tx_busy) begin
            tx_data_q  <= sum_shift[SUM_W-1 -: 8];
            tx_start_q <= 1'b1;
            guard_q    <= 1'b1;
            state_q    <= TX_WAIT;
          end
          // tx_busy only rises the cycle after tx_start, so the first cycle here is skipped
          TX_WAIT: begin
            if (guard_q) begin
              guard_q <= 1'b0;
            end else if (!tx_busy) begin
              if (k_q == KW'(NB - 1)) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= DONE;
              end else begin
                k_q     <= k_q + KW'(1);
                state_q <= SEND;
              end
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign core_start      = core_start_q;
  assign cfg_digits      = cfg_digits_q;
  assign core_byte_valid = core_byte_valid_q;
  assign core_byte       = core_byte_q;
  assign core_last       = core_last_q;
  assign tx_start        = tx_start_q;
  assign tx_data         = tx_data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign err_code        = err_code_q;

endmodule

// File: doc/aoc_job_sequencer.md
# aoc_job_sequencer

Job-level controller between the UART receiver/transmitter and a per-line puzzle solver core in the AoC FPGA designs. It parses the 4-byte job header, streams each line's packed-BCD bytes to the core with start/last framing, and accumulates the per-line results into a 64-bit sum. It then sequences the sum out through the UART transmitter as 8 bytes, MSB first.

## Interface
- SUM_W, 64, accumulator and result width; must be a multiple of 8.
- LCNT_W, 12, line-count width, fixed by the header format.
- sysclk  in  1  system clock (12 MHz on board).
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe, received byte valid.
- rx_data  in  8  received byte.
- rx_err  in  1  parity/framing error; qualified by rx_valid.
- core_start  out  1  one-cycle pulse; the core clears its line state.
- cfg_digits  out  4  header z field; stable from core_start until job end.
- core_byte_valid  out  1  strobe for core_byte.
- core_byte  out  8  line byte, two BCD digits, high nibble first.
- core_last  out  1  qualifies the final byte of a line.
- core_done  in  1  one-cycle strobe, core_result valid.
- core_result  in  SUM_W  per-line result.
- tx_start  out  1  one-cycle request to the UART TX.
- tx_data  out  8  byte to send; held from tx_start to the next tx_start.
- tx_busy  in  1  UART TX busy; must rise the cycle after tx_start.
- busy  out  1  high from header byte 0xAA accepted until job end.
- done  out  1  one-cycle pulse after the last result byte has been sent.
- err  out  1  sticky error flag.
- err_code  out  2  error cause: 1 bad header, 2 rx error, 3 overrun.

## Operation
- Header format: 0xAA, then L, then byte H, then byte Q.
  - L is the line length in bytes.
  - Line count N = {H, Q[7:4]} (12 bits).
  - Digit count z = Q[3:0].
- States: IDLE, HDR_L, HDR_H, HDR_Q, START, LINE, WAIT_CORE, SEND, TX_WAIT, DONE.
- IDLE: rx bytes other than 0xAA are ignored.
  - 0xAA goes to HDR_L, clears sum, err and err_code, and sets busy.
- HDR_Q: if L==0, N==0 or z==0: set err, err_code=1, return to IDLE.
  - Otherwise latch L, N and z, and go to START.
- START: pulse core_start for one cycle, load byte_cnt=0, go to LINE.
- LINE: each rx byte is forwarded on core_byte/core_byte_valid.
  - core_last is set when byte_cnt==L-1; that byte moves the FSM to WAIT_CORE.
- WAIT_CORE: on core_done, sum <= sum + core_result (mod 2^SUM_W, wrap silently) and line_cnt++.
  - If line_cnt==N-1, go to SEND; otherwise go to START.
- Holding register (one entry) for early bytes:
  - An rx byte arriving in WAIT_CORE or START is stored in the holding register.
  - The stored byte is forwarded as the first byte in LINE, ahead of any new byte.
  - A second byte arriving while the holding register is full sets err, err_code=3, and aborts to IDLE.
- rx_valid with rx_err high in any non-IDLE state: set err, err_code=2, abort to IDLE. In IDLE it is ignored.
- Abort: busy drops, no done, no tx. The core is not notified; the next core_start re-arms it.
- SEND: when tx_busy is low, load tx_data = sum byte k (k=0 is bits 63:56), pulse tx_start, go to TX_WAIT.
- TX_WAIT: skip one guard cycle, then wait for tx_busy low.
  - k<7: k++ and return to SEND.
  - k==7: go to DONE.
- DONE: pulse done for one cycle, drop busy, go to IDLE.
- rx bytes during SEND, TX_WAIT or DONE are ignored.

## Timing
- Reset values: all outputs 0; state IDLE; sum, counters and holding register cleared. Reset mid-job takes effect on the next edge, and no pulse is emitted after it.
- Forwarding latency: core_byte_valid is asserted the cycle after rx_valid.
- core_start timing:
  - First line: the cycle after HDR_Q accepts Q.
  - Later lines: the cycle after core_done.
- A held byte is forwarded the cycle after core_start.
- core_done is only sampled in WAIT_CORE; it is ignored elsewhere. The earliest legal core_done is the cycle after core_last.
- Same-cycle rx_valid and core_done in WAIT_CORE: the byte goes to the holding register and the accumulate still happens.
- The sum update is registered; the first tx_data is loaded no earlier than the cycle after the final accumulate.
- Minimum spacing between tx_start pulses is 3 cycles; the actual spacing is set by tx_busy.
- Throughput: one rx byte per cycle is sustainable in LINE.

## Test plan
- Reference job:
  - Header AA 32 00 5C, then five 50-byte lines with core results summing to 0x0000040C6D0C4961.
  - Required: tx bytes 00 00 04 0C 6D 0C 49 61 in order, then one done pulse, 5 core_start pulses, cfg_digits=0xC.
- Bad header AA 00 00 5C (L=0): err=1, err_code=1, no core_start, busy low after Q.
- rx_err on the 10th byte of line 2: err_code=2, abort to IDLE, no tx. A following valid job clears err and completes normally.
- Overrun: core_done held off while two bytes arrive in WAIT_CORE. Required: err_code=3. A single early byte instead is forwarded first after core_start.
- Wrap: two lines with results 0xFFFFFFFFFFFFFFFF and 0x2. Required tx 00..00 01, no error.
- Reset asserted during SEND after 3 tx bytes: all outputs 0 the next cycle, no further tx_start. Garbage bytes then 0xAA: only 0xAA starts a job.
